btn_input_ctrl: RTL and testbench



---
 rtl/btn_input_ctrl_if.sv | 25 ++
 rtl/btn_input_ctrl.sv | 137 +++++++++++++
 tb/tb_btn_input_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/btn_input_ctrl_if.sv
// Button front-end bus: raw pins, repeat enables and event acks in; conditioned
// levels, press/release pulses and sticky event flags out.
interface btn_input_ctrl_if #(
   parameter int unsigned NUM_BTN = 4
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] repeat_mask;
   logic [NUM_BTN-1:0] event_ack;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_event;

   // Board/processor side.
   modport master (
      output btn_raw, repeat_mask, event_ack,
      input  btn_level, btn_press, btn_release, btn_event
   );

   // Conditioning block side.
   modport slave (
      input  btn_raw, repeat_mask, event_ack,
      output btn_level, btn_press, btn_release, btn_event
   );
endinterface

// File: rtl/btn_input_ctrl.sv
// Per-channel button synchroniser, debouncer, edge detector and sticky event flag.
// Auto-repeat FSM is built only when BTN_REPEAT_EN is defined.
module btn_input_ctrl #(
   parameter int unsigned NUM_BTN         = 4,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 10000000,
   parameter int unsigned REPEAT_PERIOD   = 2500000
) (
   input  logic            clock,
   input  logic            reset_n,
   btn_input_ctrl_if.slave bus_io
);

   localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] pressed;
   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic [NUM_BTN-1:0] stable_q, stable_d;
   logic [DbW-1:0]     db_cnt_q [NUM_BTN];
   logic [DbW-1:0]     db_cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] rise, fall;
   logic [NUM_BTN-1:0] press_q, release_q, event_q;

   assign pressed = bus_io.btn_raw ^ {NUM_BTN{ACTIVE_LOW}};

   // Stable state flips on the cycle the counter would reach DEBOUNCE_CYCLES.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
               stable_d[i] = ~stable_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   assign rise = stable_d & ~stable_q;
   assign fall = stable_q & ~stable_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         release_q <= '0;
         event_q   <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= pressed;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         release_q <= fall;
         // A press in the ack cycle keeps the flag set.
         event_q   <= press_q | (event_q & ~bus_io.event_ack);
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RpW    = $clog2(RepMax + 1);
   localparam logic [RpW-1:0] DelayLast  = RpW'(REPEAT_DELAY - 1);
   localparam logic [RpW-1:0] PeriodLast = RpW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_st_e;

   rep_st_e        rep_st_q  [NUM_BTN];
   logic [RpW-1:0] rep_cnt_q [NUM_BTN];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         press_q <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            rep_st_q[i]  <= StIdle;
            rep_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            press_q[i] <= rise[i];
            unique case (rep_st_q[i])
               StIdle: begin
                  if (rise[i] && bus_io.repeat_mask[i]) begin
                     rep_st_q[i]  <= StDelay;
                     rep_cnt_q[i] <= '0;
                  end
               end
               StDelay, StRepeat: begin
                  // Release or mask drop wins over a pulse due in the same cycle.
                  if (fall[i] || !bus_io.repeat_mask[i]) begin
                     rep_st_q[i]  <= StIdle;
                     rep_cnt_q[i] <= '0;
                  end else if (rep_cnt_q[i] ==
                               ((rep_st_q[i] == StDelay) ? DelayLast : PeriodLast)) begin
                     press_q[i]   <= 1'b1;
                     rep_st_q[i]  <= StRepeat;
                     rep_cnt_q[i] <= '0;
                  end else begin
                     rep_cnt_q[i] <= rep_cnt_q[i] + RpW'(1);
                  end
               end
               default: begin
                  rep_st_q[i]  <= StIdle;
                  rep_cnt_q[i] <= '0;
               end
            endcase
         end
      end
   end
`else
   logic unused_repeat_mask;
   assign unused_repeat_mask = ^bus_io.repeat_mask;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         press_q <= '0;
      end else begin
         press_q <= rise;
      end
   end
`endif

   assign bus_io.btn_level   = stable_q;
   assign bus_io.btn_press   = press_q;
   assign bus_io.btn_release = release_q;
   assign bus_io.btn_event   = event_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Self-checking bench for btn_input_ctrl: per-cycle expectations are queued as stimulus
// is driven and compared on the falling edge; works with or without BTN_REPEAT_EN.
module tb_btn_input_ctrl;

   localparam int NB  = 4;
   localparam int Deb = 4;
   localparam int Dly = 10;
   localparam int Per = 3;
   localparam int Lat = Deb + 2;
   localparam int Never = 9999;
`ifdef BTN_REPEAT_EN
   localparam bit RepEn = 1'b1;
`else
   localparam bit RepEn = 1'b0;
`endif

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   btn_input_ctrl_if #(.NUM_BTN(NB)) bus ();

   btn_input_ctrl #(
      .NUM_BTN         (NB),
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (Deb),
      .REPEAT_DELAY    (Dly),
      .REPEAT_PERIOD   (Per)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus_io  (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] evt;
      string      name;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] ch;
      logic [3:0] rmask;
      int         hold;     // cycles the raw pin is held pressed
      int         drop_k;   // cycle at which repeat_mask drops to 0
      int         ack_k;
      logic [3:0] ack_m;
      int         rst_len;  // reset cycles (button already held) before k=0
      int         abort_k;  // cycle at which reset is asserted and the record ends
   } rec_t;

   exp_t       exp_q [$];
   int         n_pass  = 0;
   int         n_total = 0;
   logic [3:0] m_evt   = '0;
   logic [3:0] m_prs   = '0;
   logic [3:0] m_ack   = '0;

   // Drive one cycle of stimulus and queue the outputs expected during that cycle.
   task automatic cyc(input logic rn, input logic [3:0] raw, input logic [3:0] rmask,
                      input logic [3:0] ack, input logic [3:0] lvl, input logic [3:0] prs,
                      input logic [3:0] rel, input string name);
      exp_t e;
      @(posedge clock);
      #1;
      reset_n         = rn;
      bus.btn_raw     = ~raw;
      bus.repeat_mask = rmask;
      bus.event_ack   = ack;
      m_evt = rn ? (m_prs | (m_evt & ~m_ack)) : 4'h0;
      m_prs = rn ? prs : 4'h0;
      m_ack = ack;
      e.lvl  = lvl;
      e.prs  = prs;
      e.rel  = rel;
      e.evt  = m_evt;
      e.name = name;
      exp_q.push_back(e);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_total++;
         if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_event} ===
             {e.lvl, e.prs, e.rel, e.evt}) begin
            n_pass++;
         end else begin
            $display("FAIL %s @%0t: got lvl=%b prs=%b rel=%b evt=%b, want lvl=%b prs=%b rel=%b evt=%b",
                     e.name, $time, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_event,
                     e.lvl, e.prs, e.rel, e.evt);
         end
      end
   end

   function automatic rec_t mk(input string name, input logic [3:0] ch, input logic [3:0] rmask,
                               input int hold, input int drop_k, input int ack_k,
                               input logic [3:0] ack_m, input int rst_len, input int abort_k);
      rec_t r;
      r.name = name;  r.ch = ch;  r.rmask = rmask;  r.hold = hold;  r.drop_k = drop_k;
      r.ack_k = ack_k;  r.ack_m = ack_m;  r.rst_len = rst_len;  r.abort_k = abort_k;
      return r;
   endfunction

   task automatic run_rec(input rec_t r);
      for (int k = -r.rst_len; k <= r.hold + Lat + 3; k++) begin
         logic [3:0] raw, msk, ack, lvl, prs, rel;
         int t;
         if (k >= r.abort_k) begin
            cyc(1'b0, r.ch, r.rmask, 4'h0, 4'h0, 4'h0, 4'h0, r.name);
            break;
         end
         if (k < 0) begin
            cyc(1'b0, r.ch, r.rmask, 4'h0, 4'h0, 4'h0, 4'h0, r.name);
            continue;
         end
         t   = k - Lat;
         raw = (k < r.hold) ? r.ch : 4'h0;
         msk = (k < r.drop_k) ? r.rmask : 4'h0;
         ack = (k == r.ack_k) ? r.ack_m : ((k == r.hold + Lat + 1) ? 4'hF : 4'h0);
         lvl = (t >= 0 && t < r.hold) ? r.ch : 4'h0;
         rel = (t == r.hold) ? r.ch : 4'h0;
         prs = 4'h0;
         if (t == 0) begin
            prs = r.ch;
         end else if (RepEn && t >= Dly && t < r.hold && ((t - Dly) % Per) == 0 &&
                      k <= r.drop_k) begin
            prs = r.ch & r.rmask;
         end
         cyc(1'b1, raw, msk, ack, lvl, prs, rel, r.name);
      end
   endtask

   rec_t recs [13];

   initial begin
      recs[0]  = mk("reset_all",     4'hF, 4'h0, 8,  Never, Never,   4'h0, 3, Never);
      recs[1]  = mk("min_hold",      4'h2, 4'h0, 4,  Never, Never,   4'h0, 0, Never);
      recs[2]  = mk("repeat_30",     4'h1, 4'h1, 30, Never, Never,   4'h0, 0, Never);
      recs[3]  = mk("no_repeat",     4'h1, 4'h0, 20, Never, Never,   4'h0, 0, Never);
      recs[4]  = mk("event_ack",     4'h2, 4'h0, 30, Never, Lat + 20, 4'h2, 0, Never);
      recs[5]  = mk("ack_on_press",  4'h2, 4'h0, 8,  Never, Lat,      4'h2, 0, Never);
      recs[6]  = mk("ack_on_repeat", 4'h2, 4'h2, 14, Never, Lat + 10, 4'h2, 0, Never);
      recs[7]  = mk("mask_drop",     4'h1, 4'h1, 30, 22,    Never,   4'h0, 0, Never);
      recs[8]  = mk("indep_2_3",     4'hC, 4'h8, 18, Never, 20,      4'h8, 0, Never);
      recs[9]  = mk("all_repeat",    4'hF, 4'hF, 12, Never, Never,   4'h0, 0, Never);
      recs[10] = mk("rel_at_slot",   4'h4, 4'h4, 10, Never, Never,   4'h0, 0, Never);
      recs[11] = mk("abort_rep",     4'h1, 4'h1, 30, Never, Never,   4'h0, 0, 20);
      recs[12] = mk("after_rst",     4'h1, 4'h1, 14, Never, Never,   4'h0, 2, Never);

      bus.btn_raw     = '1;
      bus.repeat_mask = '0;
      bus.event_ack   = '0;
      #2 reset_n = 1'b0;

      foreach (recs[i]) run_rec(recs[i]);

      // A 3-cycle press is one short of the debounce window.
      for (int k = 0; k < 15; k++) begin
         cyc(1'b1, (k < 3) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "glitch_3cyc");
      end

      // Pressed 2, released 2, then held: level follows the final edge only.
      for (int k = 0; k < 26; k++) begin
         logic [3:0] raw;
         raw = ((k < 2) || (k >= 4 && k < 16)) ? 4'h1 : 4'h0;
         cyc(1'b1, raw, 4'h0, (k == 23) ? 4'h1 : 4'h0,
             (k >= 10 && k < 22) ? 4'h1 : 4'h0, (k == 10) ? 4'h1 : 4'h0,
             (k == 22) ? 4'h1 : 4'h0, "bounce");
      end

      @(negedge clock);
      @(negedge clock);
      n_total++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
